if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 159 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: one outstanding memory request, one-entry skid buffer for stalls.
// Define FETCH_PERF_EN to add fetched-instruction and bubble counters.
module if_fetch_unit #(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [31:0]       imem_rdata_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic              valid_o,
    output logic              flush_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       fetch_cnt_o,
    output logic [31:0]       bubble_cnt_o
`endif
);

    typedef enum logic [1:0] {StFetch, StHold, StDiscard} state_t;

    state_t            state, state_nx;
    logic              running;
    logic [ADDR_W-1:0] addr, addr_nx;
    logic [ADDR_W-1:0] target, target_nx;
    logic [31:0]       skid_instr, skid_instr_nx;
    logic [ADDR_W-1:0] skid_pc4, skid_pc4_nx;
    logic [31:0]       instr_nx;
    logic [ADDR_W-1:0] pc4_nx;
    logic              valid_nx;
    logic              hs, out_load;
    logic [ADDR_W-1:0] redir_pc, pc_inc;
    logic              unused_pc_lsbs;

    assign redir_pc       = {redirect_pc_i[ADDR_W-1:2], 2'b00};
    assign unused_pc_lsbs = ^redirect_pc_i[1:0];
    assign pc_inc         = addr + ADDR_W'(4);
    assign hs             = imem_req_o && imem_ack_i;
    // Delivered outputs move only when not stalled, or when a redirect kills them.
    assign out_load       = redirect_i || !stall_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= StFetch;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            StFetch: begin
                if (redirect_i)         state_nx = (hs || !running) ? StFetch : StDiscard;
                else if (hs && stall_i) state_nx = StHold;
            end
            StHold:    if (redirect_i || !stall_i) state_nx = StFetch;
            StDiscard: if (hs) state_nx = StFetch;
            default:   state_nx = StFetch;
        endcase
    end

    always_comb begin
        imem_req_o  = running && (state != StHold);
        imem_addr_o = addr;
        flush_o     = redirect_i;
    end

    always_comb begin
        addr_nx       = addr;
        target_nx     = target;
        skid_instr_nx = skid_instr;
        skid_pc4_nx   = skid_pc4;
        instr_nx      = instr_o;
        pc4_nx        = pc_plus4_o;
        valid_nx      = valid_o;
        if (out_load) begin
            valid_nx = 1'b0;
            instr_nx = '0;
        end
        case (state)
            StFetch: begin
                if (redirect_i) begin
                    // With no request outstanding the target can be taken directly.
                    if (hs || !running) addr_nx = redir_pc;
                    else                target_nx = redir_pc;
                end else if (hs) begin
                    if (stall_i) begin
                        skid_instr_nx = imem_rdata_i;
                        skid_pc4_nx   = pc_inc;
                    end else begin
                        instr_nx = imem_rdata_i;
                        pc4_nx   = pc_inc;
                        valid_nx = 1'b1;
                        addr_nx  = pc_inc;
                    end
                end
            end
            StHold: begin
                if (redirect_i) begin
                    addr_nx = redir_pc;
                end else if (!stall_i) begin
                    instr_nx = skid_instr;
                    pc4_nx   = skid_pc4;
                    valid_nx = 1'b1;
                    addr_nx  = skid_pc4;
                end
            end
            StDiscard: begin
                if (redirect_i) begin
                    target_nx = redir_pc;
                    if (hs) addr_nx = redir_pc;
                end else if (hs) begin
                    addr_nx = target;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            running    <= 1'b0;
            addr       <= RESET_PC;
            target     <= '0;
            skid_instr <= '0;
            skid_pc4   <= '0;
            instr_o    <= '0;
            pc_plus4_o <= '0;
            valid_o    <= 1'b0;
        end else begin
            running    <= 1'b1;
            addr       <= addr_nx;
            target     <= target_nx;
            skid_instr <= skid_instr_nx;
            skid_pc4   <= skid_pc4_nx;
            instr_o    <= instr_nx;
            pc_plus4_o <= pc4_nx;
            valid_o    <= valid_nx;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (out_load && valid_nx)              fetch_cnt_o  <= fetch_cnt_o + 32'd1;
            if (out_load && !valid_nx && !stall_i) bubble_cnt_o <= bubble_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed table-driven bench for if_fetch_unit; memory returns a fixed function of the address.
module tb_if_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i, redirect_i, imem_ack_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o, valid_o, flush_o;
    logic [31:0] imem_addr_o, imem_rdata_i, instr_o, pc_plus4_o;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_o, bubble_cnt_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h1300_0013;
    endfunction

    assign imem_rdata_i = mem_word(imem_addr_o);

    if_fetch_unit dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .instr_o      (instr_o),
        .pc_plus4_o   (pc_plus4_o),
        .valid_o      (valid_o),
        .flush_o      (flush_o)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt_o  (fetch_cnt_o),
        .bubble_cnt_o (bubble_cnt_o)
`endif
    );

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic        ack;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_ins;
        logic [31:0] e_pc4;
    } vec_t;

    localparam int NV = 33;
    vec_t tbl [NV];

    function automatic vec_t v(input logic st, input logic rd, input logic [31:0] rpc,
                               input logic ack, input logic req, input logic [31:0] addr,
                               input logic vld, input logic [31:0] ins, input logic [31:0] pc4);
        vec_t r;
        r.st = st; r.rd = rd; r.rpc = rpc; r.ack = ack;
        r.e_req = req; r.e_addr = addr; r.e_vld = vld; r.e_ins = ins; r.e_pc4 = pc4;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " req"}, {31'd0, imem_req_o}, 32'd0);
        check({tag, " addr"}, imem_addr_o, 32'd0);
        check({tag, " valid"}, {31'd0, valid_o}, 32'd0);
        check({tag, " instr"}, instr_o, 32'd0);
        check({tag, " pc4"}, pc_plus4_o, 32'd0);
    endtask

    initial begin
        // st rd rpc          ack | req addr          vld instr                  pc4
        tbl[0]  = v(0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,                  32'h0);
        tbl[1]  = v(0, 0, 32'h0,        1, 1, 32'h0,        0, 32'h0,                  32'h0);
        tbl[2]  = v(0, 0, 32'h0,        1, 1, 32'h4,        1, mem_word(32'h0),        32'h4);
        tbl[3]  = v(0, 0, 32'h0,        1, 1, 32'h8,        1, mem_word(32'h4),        32'h8);
        tbl[4]  = v(0, 0, 32'h0,        1, 1, 32'hC,        1, mem_word(32'h8),        32'hC);
        tbl[5]  = v(0, 0, 32'h0,        0, 1, 32'h10,       1, mem_word(32'hC),        32'h10);
        tbl[6]  = v(0, 0, 32'h0,        0, 1, 32'h10,       0, 32'h0,                  32'h10);
        tbl[7]  = v(0, 0, 32'h0,        0, 1, 32'h10,       0, 32'h0,                  32'h10);
        tbl[8]  = v(0, 0, 32'h0,        1, 1, 32'h10,       0, 32'h0,                  32'h10);
        tbl[9]  = v(0, 0, 32'h0,        1, 1, 32'h14,       1, mem_word(32'h10),       32'h14);
        tbl[10] = v(0, 0, 32'h0,        1, 1, 32'h18,       1, mem_word(32'h14),       32'h18);
        tbl[11] = v(0, 0, 32'h0,        1, 1, 32'h1C,       1, mem_word(32'h18),       32'h1C);
        tbl[12] = v(1, 0, 32'h0,        1, 1, 32'h20,       1, mem_word(32'h1C),       32'h20);
        tbl[13] = v(1, 0, 32'h0,        1, 0, 32'h20,       1, mem_word(32'h1C),       32'h20);
        tbl[14] = v(0, 0, 32'h0,        1, 0, 32'h20,       1, mem_word(32'h1C),       32'h20);
        tbl[15] = v(0, 0, 32'h0,        1, 1, 32'h24,       1, mem_word(32'h20),       32'h24);
        tbl[16] = v(0, 1, 32'h40,       1, 1, 32'h28,       1, mem_word(32'h24),       32'h28);
        tbl[17] = v(0, 1, 32'h103,      0, 1, 32'h40,       0, 32'h0,                  32'h28);
        tbl[18] = v(0, 0, 32'h0,        0, 1, 32'h40,       0, 32'h0,                  32'h28);
        tbl[19] = v(0, 0, 32'h0,        1, 1, 32'h40,       0, 32'h0,                  32'h28);
        tbl[20] = v(0, 0, 32'h0,        1, 1, 32'h100,      0, 32'h0,                  32'h28);
        tbl[21] = v(1, 0, 32'h0,        1, 1, 32'h104,      1, mem_word(32'h100),      32'h104);
        tbl[22] = v(1, 1, 32'h300,      0, 0, 32'h104,      1, mem_word(32'h100),      32'h104);
        tbl[23] = v(0, 1, 32'h500,      0, 1, 32'h300,      0, 32'h0,                  32'h104);
        tbl[24] = v(0, 1, 32'h600,      0, 1, 32'h300,      0, 32'h0,                  32'h104);
        tbl[25] = v(0, 0, 32'h0,        1, 1, 32'h300,      0, 32'h0,                  32'h104);
        tbl[26] = v(0, 0, 32'h0,        1, 1, 32'h600,      0, 32'h0,                  32'h104);
        tbl[27] = v(1, 0, 32'h0,        0, 1, 32'h604,      1, mem_word(32'h600),      32'h604);
        tbl[28] = v(0, 0, 32'h0,        0, 1, 32'h604,      1, mem_word(32'h600),      32'h604);
        tbl[29] = v(0, 1, 32'hFFFF_FFFC, 1, 1, 32'h604,     0, 32'h0,                  32'h604);
        tbl[30] = v(0, 0, 32'h0,        1, 1, 32'hFFFF_FFFC, 0, 32'h0,                 32'h604);
        tbl[31] = v(0, 0, 32'h0,        1, 1, 32'h0,        1, mem_word(32'hFFFF_FFFC), 32'h0);
        tbl[32] = v(0, 0, 32'h0,        0, 1, 32'h4,        1, mem_word(32'h0),        32'h4);

        rst_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; imem_ack_i = 1'b0;
        #2;
        check_all_zero("reset");
        @(negedge clk_i);
        @(negedge clk_i);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk_i);
            if (i == 0) rst_i = 1'b1;
            stall_i       = tbl[i].st;
            redirect_i    = tbl[i].rd;
            redirect_pc_i = tbl[i].rpc;
            imem_ack_i    = tbl[i].ack;
            #1;
            check($sformatf("row%0d req", i), {31'd0, imem_req_o}, {31'd0, tbl[i].e_req});
            check($sformatf("row%0d addr", i), imem_addr_o, tbl[i].e_addr);
            check($sformatf("row%0d flush", i), {31'd0, flush_o}, {31'd0, tbl[i].rd});
            check($sformatf("row%0d valid", i), {31'd0, valid_o}, {31'd0, tbl[i].e_vld});
            check($sformatf("row%0d instr", i), instr_o, tbl[i].e_ins);
            check($sformatf("row%0d pc4", i), pc_plus4_o, tbl[i].e_pc4);
        end

        // Asynchronous reset while the request to 0x4 is still waiting for its ack.
        @(negedge clk_i);
        stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; imem_ack_i = 1'b0;
        #1;
        check("wait req", {31'd0, imem_req_o}, 32'd1);
        check("wait addr", imem_addr_o, 32'h4);
        check("wait valid", {31'd0, valid_o}, 32'd0);
`ifdef FETCH_PERF_EN
        check("fetch_cnt", fetch_cnt_o, 32'd14);
        check("bubble_cnt", bubble_cnt_o, 32'd14);
`endif
        rst_i = 1'b0;
        #1;
        check_all_zero("async rst");
`ifdef FETCH_PERF_EN
        check("rst fetch_cnt", fetch_cnt_o, 32'd0);
        check("rst bubble_cnt", bubble_cnt_o, 32'd0);
`endif
        imem_ack_i = 1'b1;
        @(negedge clk_i);
        #1;
        check_all_zero("held rst");
        rst_i = 1'b1;
        #1;
        check("release req", {31'd0, imem_req_o}, 32'd0);
        @(negedge clk_i);
        #1;
        check("restart req", {31'd0, imem_req_o}, 32'd1);
        check("restart addr", imem_addr_o, 32'h0);
        check("restart valid", {31'd0, valid_o}, 32'd0);
        @(negedge clk_i);
        #1;
        check("restart valid2", {31'd0, valid_o}, 32'd1);
        check("restart instr", instr_o, mem_word(32'h0));
        check("restart pc4", pc_plus4_o, 32'h4);
        check("restart addr2", imem_addr_o, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
